pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register that generalises the existing fixed-field MEMWB-style stage registers.
- Carries an opaque DATA_W-bit payload between two pipeline stages with a valid/ready handshake and synchronous flush.
- Has an optional two-entry skid buffer, so upstream ready can be registered without losing throughput.
- Exports a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 64: payload width in bits. A packed pipe struct is cast onto this bus.
- SKID, 1: 0 = single register, in_ready_o combinational; 1 = two-entry skid buffer, in_ready_o registered.
- CNT_W, 32: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- flush_i  in  1  synchronous flush; discards all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream payload valid.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DATA_W  downstream payload.
- stall_cnt_o  out  CNT_W  count of cycles with out_valid_o=1 and out_ready_i=0.

Behaviour:
- Definitions: push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Reset (rst_i=1 at an edge):
  - State becomes EMPTY.
  - out_valid_o=0, out_data_o=0, stall_cnt_o=0; skid register cleared to 0.
  - in_ready_o is forced to 0 combinationally while rst_i=1. It is 1 in the first cycle after reset deasserts.
- Latency: a pushed payload appears on out_data_o with out_valid_o=1 the next cycle, for both SKID values.
- Ordering: strict FIFO. No payload is ever dropped or duplicated, except by flush.
- Hold rule: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change (unless flush_i or rst_i).
- SKID=0:
  - in_ready_o = ~rst_i & (~out_valid_o | out_ready_i).
  - On push: main register <= in_data_i, out_valid_o <= 1.
  - On pop with no push: out_valid_o <= 0.
  - Sustains one transfer per cycle.
- SKID=1, states EMPTY, ONE, FULL:
  - out_* are driven from the main register; the skid register holds the second entry.
  - in_ready_o = ~rst_i & (state != FULL); the state term comes from a flop.
  - EMPTY: push -> ONE, main <= in. No push -> stay.
  - ONE, push & pop -> ONE, main <= in.
  - ONE, push & ~pop -> FULL, skid <= in.
  - ONE, ~push & pop -> EMPTY.
  - ONE, neither -> stay.
  - FULL: pop -> ONE, main <= skid. No pop -> stay. No push is possible because in_ready_o=0.
  - out_valid_o = (state != EMPTY).
- Flush:
  - flush_i=1 at an edge -> next state EMPTY and out_valid_o=0.
  - Any push or pop in the same cycle is ignored: the push is discarded, and the pop still counts as a handshake seen by downstream.
  - Data registers may keep stale values, since they are don't-care while invalid.
  - Flush has priority over push and pop; rst_i has priority over flush_i.
- Stall counter:
  - Increments by 1 on each edge where out_valid_o=1 and out_ready_i=0 and rst_i=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Unaffected by flush_i.
- Simultaneous push and pop in FULL cannot occur. In ONE with push and pop, main is overwritten and skid is untouched.
- No combinational path from in_valid_i to out_valid_o or in_ready_o.
- For SKID=1 there is no combinational path from out_ready_i to in_ready_o.

Test Plan:
1. Reset then stream (SKID=1, DATA_W=64): reset 2 cycles; push 0x1, 0x2, 0x3 on consecutive cycles with out_ready_i=1 -> out_data_o shows 0x1, 0x2, 0x3 one cycle after each push, with out_valid_o=1 continuously; in_ready_o=1 throughout.
2. Backpressure fill (SKID=1): out_ready_i=0, push 0xA then 0xB -> state FULL, in_ready_o=0 next cycle, out_data_o holds 0xA. Raise out_ready_i -> 0xA then 0xB popped in order; in_ready_o returns to 1 one cycle after the first pop.
3. Flush mid-operation: FULL with 0xA and 0xB; assert flush_i together with in_valid_i for 0xC -> next cycle out_valid_o=0 and state EMPTY. 0xC, 0xA and 0xB never appear; a following push of 0xD emerges normally.
4. SKID=0 pass-through ready: out_valid_o=1 holding 0x5 with out_ready_i=1 -> in_ready_o=1 in the same cycle. A push of 0x6 replaces 0x5 the next cycle with no bubble.
5. Stall counter saturation (CNT_W=4): hold out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15; reset returns it to 0.
6. Reset during FULL: assert rst_i with both entries held -> in_ready_o=0 while rst_i=1. Next cycle out_valid_o=0, out_data_o=0, stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with an optional two-entry skid buffer,
// a synchronous flush and a saturating stall-cycle counter.
//
// SKID=1: in_ready_o depends only on rst_i and the state flop, so it has no path from
// out_ready_i. A second entry is held in the skid register while downstream stalls.
// SKID=0: one register. in_ready_o passes out_ready_i through combinationally, so a
// push can only happen in ONE together with a pop, and FULL is never reached.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              push;
    logic              pop;

    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;
    assign stall_cnt_o = stall_cnt_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready_o = ~rst_i & (state_q != StFull);
        end else begin : g_noskid
            assign in_ready_o = ~rst_i & (~out_valid_o | out_ready_i);
        end
    endgenerate

    // Occupancy FSM and payload registers; flush empties the stage but leaves data stale.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q <= StOne;
                        main_q  <= in_data_i;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_q <= in_data_i;
                    end else if (push) begin
                        state_q <= StFull;
                        skid_q  <= in_data_i;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles (valid held against backpressure); flush-independent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [3:0]  a_cnt;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [31:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (a_flush),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_data_o  (a_out_data),
        .stall_cnt_o (a_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(32)) u_noskid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (b_flush),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .stall_cnt_o (b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;

        // Reset for two cycles
        step();
        step();
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", a_out_data, 64'd0);
        check("rst_cnt", 64'(a_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Stream 1,2,3 with downstream always ready
        a_out_ready = 1; a_in_valid = 1;
        a_in_data = 64'h1; step();
        check("s1_data", a_out_data, 64'h1);
        check("s1_valid", 64'(a_out_valid), 64'd1);
        check("s1_ready", 64'(a_in_ready), 64'd1);
        a_in_data = 64'h2; step();
        check("s2_data", a_out_data, 64'h2);
        check("s2_valid", 64'(a_out_valid), 64'd1);
        a_in_data = 64'h3; step();
        check("s3_data", a_out_data, 64'h3);
        check("s3_ready", 64'(a_in_ready), 64'd1);
        a_in_valid = 0; step();
        check("s_drain_valid", 64'(a_out_valid), 64'd0);
        check("s_cnt", 64'(a_cnt), 64'd0);

        // Backpressure fill then ordered drain
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 64'hA; step();
        check("bp_one_ready", 64'(a_in_ready), 64'd1);
        check("bp_one_data", a_out_data, 64'hA);
        a_in_data = 64'hB; step();
        a_in_valid = 0;
        check("bp_full_ready", 64'(a_in_ready), 64'd0);
        check("bp_full_data", a_out_data, 64'hA);
        check("bp_full_valid", 64'(a_out_valid), 64'd1);
        check("bp_cnt", 64'(a_cnt), 64'd1);
        a_out_ready = 1; step();
        check("bp_pop1_data", a_out_data, 64'hB);
        check("bp_pop1_ready", 64'(a_in_ready), 64'd1);
        step();
        check("bp_pop2_valid", 64'(a_out_valid), 64'd0);
        check("bp_cnt_after", 64'(a_cnt), 64'd1);

        // Flush while FULL, with an offered push of 0xC
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 64'hA; step();
        a_in_data = 64'hB; step();
        check("fl_full_ready", 64'(a_in_ready), 64'd0);
        a_flush = 1; a_in_data = 64'hC; step();
        a_flush = 0; a_in_valid = 0;
        check("fl_valid", 64'(a_out_valid), 64'd0);
        check("fl_ready", 64'(a_in_ready), 64'd1);
        check("fl_cnt", 64'(a_cnt), 64'd3);
        a_out_ready = 1; step();
        check("fl_nothing_left", 64'(a_out_valid), 64'd0);
        a_in_valid = 1; a_in_data = 64'hD; step();
        check("fl_d_data", a_out_data, 64'hD);
        check("fl_d_valid", 64'(a_out_valid), 64'd1);
        // Flush in ONE with an accepted push and a pop on the same edge
        a_in_data = 64'hE; a_flush = 1; step();
        a_flush = 0; a_in_valid = 0;
        check("fl_one_valid", 64'(a_out_valid), 64'd0);
        step();
        check("fl_one_after", 64'(a_out_valid), 64'd0);

        // Stall counter saturation (3 already counted)
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h7; step();
        a_in_valid = 0;
        repeat (12) step();
        check("sat_cnt_15", 64'(a_cnt), 64'd15);
        repeat (8) step();
        check("sat_cnt_hold", 64'(a_cnt), 64'd15);
        check("sat_data_hold", a_out_data, 64'h7);
        check("sat_valid_hold", 64'(a_out_valid), 64'd1);

        // Reset while FULL
        a_in_valid = 1; a_in_data = 64'h8; step();
        a_in_valid = 0;
        check("rf_full_ready", 64'(a_in_ready), 64'd0);
        rst = 1; #1;
        check("rf_ready_in_rst", 64'(a_in_ready), 64'd0);
        step();
        check("rf_valid", 64'(a_out_valid), 64'd0);
        check("rf_data", a_out_data, 64'd0);
        check("rf_cnt", 64'(a_cnt), 64'd0);
        rst = 0; #1;
        check("rf_ready_after", 64'(a_in_ready), 64'd1);

        // SKID=0: pass-through ready and bubble-free replacement
        b_in_valid = 1; b_in_data = 64'h5; step();
        b_in_valid = 0;
        check("ns_data5", b_out_data, 64'h5);
        check("ns_ready_stalled", 64'(b_in_ready), 64'd0);
        step();
        check("ns_hold_data", b_out_data, 64'h5);
        check("ns_cnt", b_cnt, 64'd1);
        b_out_ready = 1; #1;
        check("ns_ready_pass", 64'(b_in_ready), 64'd1);
        b_in_valid = 1; b_in_data = 64'h6; step();
        b_in_valid = 0;
        check("ns_data6", b_out_data, 64'h6);
        check("ns_valid6", 64'(b_out_valid), 64'd1);
        step();
        check("ns_drain", 64'(b_out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
